// File: rtl/gf180mcu_scan_pkg.sv
// Shared definitions for the scan chain sequencer.
//   scan_state_e : sequencer phases, IDLE -> LOAD -> CAPTURE -> UNLOAD -> RESULT
//   cnt_width()  : width of the phase counter, sized so that both the shift length
//                  and the capture length fit without wrapping.
package gf180mcu_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_RESULT
    } scan_state_e;

    // Normally $clog2(chain_len+1); a capture phase longer than the chain also
    // has to fit in the same counter.
    function automatic int cnt_width(input int chain_len, input int cap_cycles);
        int longest;
        longest = (cap_cycles > chain_len) ? cap_cycles : chain_len;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_scan_shreg.sv
// Pattern shift register for the scan sequencer.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture load_data (has priority over shift)
//   shift      : move contents one place toward bit 0, zero fill at the top
//   load_data  : WIDTH-bit word to load
//   lsb_out    : current bit 0, the next bit to be driven into the chain
module gf180mcu_scan_shreg
    import gf180mcu_scan_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             lsb_out
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign lsb_out = shreg_q[0];

endmodule

// File: rtl/gf180mcu_scan_chain_ctrl.sv
// Scan load / capture / unload sequencer driving a chain of scan flops.
//   CLK, RN             : clock (rising edge) and asynchronous active-low reset
//   pat_valid/ready/data: pattern handshake, bit 0 is shifted in first
//   SE, SI              : registered scan enable and scan data toward the chain head
//   SO                  : chain tail output
//   res_valid/ready/data: response handshake, bit 0 is the first bit unloaded
//   busy                : sequencer is not idle
// Every output comes straight from a flop, so SE and SI only move on CLK edges.
module gf180mcu_scan_chain_ctrl
    import gf180mcu_scan_pkg::*;
#(
    parameter int CHAIN_LEN  = 32,
    parameter int CAP_CYCLES = 1,
    parameter int CHAIN_INV  = 0,
    parameter int FILL_BIT   = 0
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CHAIN_LEN-1:0] res_data,
    output logic                 busy
);

    localparam int            CW         = cnt_width(CHAIN_LEN, CAP_CYCLES);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] LAST_CAP   = CW'((CAP_CYCLES == 0) ? 0 : CAP_CYCLES - 1);
    localparam logic          INV_BIT    = 1'(CHAIN_INV);
    localparam logic          FILL       = 1'(FILL_BIT);

    scan_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 pat_ready_q, pat_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic [CHAIN_LEN-1:0] res_data_q, res_data_d;
    logic                 busy_q, busy_d;
    logic                 shreg_load;
    logic                 shreg_shift;
    logic                 shreg_lsb;

    // SI is registered, so bit 0 is launched straight from pat_data at accept and the
    // shift register holds the remaining bits; its LSB is always the next bit to send.
    gf180mcu_scan_shreg #(
        .WIDTH(CHAIN_LEN)
    ) u_shreg (
        .clk      (CLK),
        .rst_n    (RN),
        .load     (shreg_load),
        .shift    (shreg_shift),
        .load_data(pat_data >> 1),
        .lsb_out  (shreg_lsb)
    );

    // Next state, counter and SI. SI is chosen for the phase that starts on the
    // coming edge, which is why phase exits pick the following phase's SI value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        si_d        = 1'b0;
        res_data_d  = res_data_q;
        shreg_load  = 1'b0;
        shreg_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pat_valid && pat_ready_q) begin
                    state_d    = ST_LOAD;
                    shreg_load = 1'b1;
                    si_d       = pat_data[0];
                    res_data_d = '0;
                end
            end
            ST_LOAD: begin
                shreg_shift = 1'b1;
                si_d        = shreg_lsb;
                if (cnt_q == LAST_SHIFT) begin
                    cnt_d = '0;
                    if (CAP_CYCLES == 0) begin
                        state_d = ST_UNLOAD;
                        si_d    = FILL;
                    end else begin
                        state_d = ST_CAPTURE;
                        si_d    = 1'b0;
                    end
                end
            end
            ST_CAPTURE: begin
                if (cnt_q == LAST_CAP) begin
                    state_d = ST_UNLOAD;
                    cnt_d   = '0;
                    si_d    = FILL;
                end
            end
            ST_UNLOAD: begin
                si_d = FILL;
                for (int i = 0; i < CHAIN_LEN; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_data_d[i] = SO ^ INV_BIT;
                    end
                end
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_RESULT;
                    cnt_d   = '0;
                    si_d    = 1'b0;
                end
            end
            ST_RESULT: begin
                cnt_d = '0;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Handshake and enable outputs are decoded from the next state so they
        // change on the same edge as the state itself.
        se_d        = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
        pat_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_RESULT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            se_q        <= 1'b0;
            si_q        <= 1'b0;
            pat_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            se_q        <= se_d;
            si_q        <= si_d;
            pat_ready_q <= pat_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign SE        = se_q;
    assign SI        = si_q;
    assign pat_ready = pat_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gf180mcu_scan_chain_ctrl.sv
// Bench for the scan sequencer. Three 8-flop controllers run side by side, each in
// front of its own behavioural scan chain (SE mux plus a functional D input):
//   dut 0 : no capture, plain chain, functional D = ~Q
//   dut 1 : one capture cycle, functional D tied 0
//   dut 2 : no capture, chain with one inverting stage at the tail, fill bit 1
module tb_gf180mcu_scan_chain_ctrl;

    logic            CLK;
    logic            RN;
    logic [2:0]      patValid;
    logic [2:0]      patReady;
    logic [2:0][7:0] patData;
    logic [2:0]      se;
    logic [2:0]      si;
    logic [2:0]      so;
    logic [2:0]      resValid;
    logic [2:0]      resReady;
    logic [2:0][7:0] resData;
    logic [2:0]      busyOut;

    logic [7:0] chain0;
    logic [7:0] chain1;
    logic [7:0] chain2;

    int checks = 0;
    int errors = 0;

    gf180mcu_scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(0), .CHAIN_INV(0), .FILL_BIT(0)) dut0 (
        .CLK(CLK), .RN(RN), .pat_valid(patValid[0]), .pat_ready(patReady[0]),
        .pat_data(patData[0]), .SE(se[0]), .SI(si[0]), .SO(so[0]),
        .res_valid(resValid[0]), .res_ready(resReady[0]), .res_data(resData[0]),
        .busy(busyOut[0])
    );

    gf180mcu_scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1), .CHAIN_INV(0), .FILL_BIT(0)) dut1 (
        .CLK(CLK), .RN(RN), .pat_valid(patValid[1]), .pat_ready(patReady[1]),
        .pat_data(patData[1]), .SE(se[1]), .SI(si[1]), .SO(so[1]),
        .res_valid(resValid[1]), .res_ready(resReady[1]), .res_data(resData[1]),
        .busy(busyOut[1])
    );

    gf180mcu_scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(0), .CHAIN_INV(1), .FILL_BIT(1)) dut2 (
        .CLK(CLK), .RN(RN), .pat_valid(patValid[2]), .pat_ready(patReady[2]),
        .pat_data(patData[2]), .SE(se[2]), .SI(si[2]), .SO(so[2]),
        .res_valid(resValid[2]), .res_ready(resReady[2]), .res_data(resData[2]),
        .busy(busyOut[2])
    );

    // Free-running clock, 10 time units per period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural scan chains: SI enters bit 0, the tail is bit 7
    always @(posedge CLK) begin
        chain0 <= se[0] ? {chain0[6:0], si[0]} : ~chain0;
        chain1 <= se[1] ? {chain1[6:0], si[1]} : 8'h00;
        chain2 <= se[2] ? {chain2[6:0], si[2]} : ~chain2;
    end

    assign so[0] = chain0[7];
    assign so[1] = chain1[7];
    assign so[2] = ~chain2[7];

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one pattern to controller k and return on the negedge of the first
    // cycle after the accepting edge (cycle 1 of the run)
    task automatic applyStimulus(input int k, input logic [7:0] pat);
        int waitCycles;
        waitCycles = 0;
        @(negedge CLK);
        while (!patReady[k] && waitCycles < 20) begin
            @(negedge CLK);
            waitCycles++;
        end
        checkOutput("patReadyBeforeAccept", 32'(patReady[k]), 32'd1);
        patValid[k] = 1'b1;
        patData[k]  = pat;
        @(posedge CLK);
        @(negedge CLK);
        patValid[k] = 1'b0;
    endtask

    // Watch a run from cycle 1 until res_valid rises, counting SE levels on the way
    // and sampling SI in cycle 12, which is inside UNLOAD for every controller here
    task automatic observeRun(input int k, output int firstValid, output int seHigh,
                              output int seLow, output logic siUnload);
        firstValid = 0;
        seHigh     = 0;
        seLow      = 0;
        siUnload   = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (resValid[k]) begin
                firstValid = cyc;
                break;
            end
            if (se[k]) seHigh++;
            else       seLow++;
            if (cyc == 12) siUnload = si[k];
            @(negedge CLK);
        end
    endtask

    // Complete the result handshake on controller k, then confirm it is idle again
    task automatic finishResult(input int k);
        resReady[k] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        resReady[k] = 1'b0;
        checkOutput("resValidAfterHandshake", 32'(resValid[k]), 32'd0);
        checkOutput("patReadyAfterHandshake", 32'(patReady[k]), 32'd1);
        checkOutput("busyAfterHandshake", 32'(busyOut[k]), 32'd0);
    endtask

    initial begin
        int   firstValid;
        int   seHigh;
        int   seLow;
        logic siUnload;

        RN       = 1'b1;
        patValid = '0;
        patData  = '0;
        resReady = '0;
        #1 RN = 1'b0;

        // Reset values while RN is held low
        #12;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rstPatReady", 32'(patReady[k]), 32'd0);
            checkOutput("rstSe", 32'(se[k]), 32'd0);
            checkOutput("rstSi", 32'(si[k]), 32'd0);
            checkOutput("rstResValid", 32'(resValid[k]), 32'd0);
            checkOutput("rstResData", 32'(resData[k]), 32'd0);
            checkOutput("rstBusy", 32'(busyOut[k]), 32'd0);
        end
        @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            checkOutput("postRstPatReady", 32'(patReady[k]), 32'd1);
        end

        // Pure shift-through: A5 comes back unchanged after 16 SE cycles
        applyStimulus(0, 8'hA5);
        checkOutput("loadBusy", 32'(busyOut[0]), 32'd1);
        checkOutput("loadPatReady", 32'(patReady[0]), 32'd0);
        checkOutput("loadFirstSi", 32'(si[0]), 32'd1);
        observeRun(0, firstValid, seHigh, seLow, siUnload);
        checkOutput("shiftFirstValid", 32'(firstValid), 32'd17);
        checkOutput("shiftSeHigh", 32'(seHigh), 32'd16);
        checkOutput("shiftSeLow", 32'(seLow), 32'd0);
        checkOutput("shiftFillBit", 32'(siUnload), 32'd0);
        checkOutput("shiftResData", 32'(resData[0]), 32'hA5);
        checkOutput("resultSe", 32'(se[0]), 32'd0);
        finishResult(0);

        // Response held back for 10 cycles while a new pattern is offered
        applyStimulus(0, 8'h5A);
        observeRun(0, firstValid, seHigh, seLow, siUnload);
        checkOutput("holdFirstValid", 32'(firstValid), 32'd17);
        patValid[0] = 1'b1;
        patData[0]  = 8'hC3;
        for (int c = 0; c < 10; c++) begin
            checkOutput("holdResValid", 32'(resValid[0]), 32'd1);
            checkOutput("holdResData", 32'(resData[0]), 32'h5A);
            checkOutput("holdPatReady", 32'(patReady[0]), 32'd0);
            checkOutput("holdSe", 32'(se[0]), 32'd0);
            @(negedge CLK);
        end

        // Back-to-back: pat_valid stays high through the handshake, so C3 is
        // accepted on the very next edge and must come back without any 5A bits
        resReady[0] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        resReady[0] = 1'b0;
        checkOutput("b2bResValidCleared", 32'(resValid[0]), 32'd0);
        checkOutput("b2bPatReady", 32'(patReady[0]), 32'd1);
        checkOutput("b2bIdleBusy", 32'(busyOut[0]), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        patValid[0] = 1'b0;
        checkOutput("b2bAcceptBusy", 32'(busyOut[0]), 32'd1);
        checkOutput("b2bAcceptPatReady", 32'(patReady[0]), 32'd0);
        checkOutput("b2bAcceptSe", 32'(se[0]), 32'd1);
        observeRun(0, firstValid, seHigh, seLow, siUnload);
        checkOutput("b2bFirstValid", 32'(firstValid), 32'd17);
        checkOutput("b2bResData", 32'(resData[0]), 32'hC3);
        finishResult(0);

        // One capture cycle into a chain whose functional D is 0
        applyStimulus(1, 8'hFF);
        observeRun(1, firstValid, seHigh, seLow, siUnload);
        checkOutput("capFirstValid", 32'(firstValid), 32'd18);
        checkOutput("capSeHigh", 32'(seHigh), 32'd16);
        checkOutput("capSeLow", 32'(seLow), 32'd1);
        checkOutput("capFillBit", 32'(siUnload), 32'd0);
        checkOutput("capResData", 32'(resData[1]), 32'h00);
        finishResult(1);

        // Inverting chain: the controller undoes the inversion
        applyStimulus(2, 8'h3C);
        observeRun(2, firstValid, seHigh, seLow, siUnload);
        checkOutput("invFirstValid", 32'(firstValid), 32'd17);
        checkOutput("invSeHigh", 32'(seHigh), 32'd16);
        checkOutput("invFillBit", 32'(siUnload), 32'd1);
        checkOutput("invResData", 32'(resData[2]), 32'h3C);
        finishResult(2);

        // Reset in the middle of LOAD drops everything asynchronously
        applyStimulus(0, 8'h81);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("midLoadSe", 32'(se[0]), 32'd1);
        #2 RN = 1'b0;
        #1;
        checkOutput("midRstSe", 32'(se[0]), 32'd0);
        checkOutput("midRstBusy", 32'(busyOut[0]), 32'd0);
        checkOutput("midRstResValid", 32'(resValid[0]), 32'd0);
        checkOutput("midRstPatReady", 32'(patReady[0]), 32'd0);
        checkOutput("midRstResData", 32'(resData[0]), 32'd0);
        @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        checkOutput("midRstReleasePatReady", 32'(patReady[0]), 32'd1);
        checkOutput("midRstReleaseSe", 32'(se[0]), 32'd0);

        // A full run after the aborted one still works
        applyStimulus(0, 8'h81);
        observeRun(0, firstValid, seHigh, seLow, siUnload);
        checkOutput("afterRstFirstValid", 32'(firstValid), 32'd17);
        checkOutput("afterRstResData", 32'(resData[0]), 32'h81);
        finishResult(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
